// File: rtl/axis_dma_pkg.sv
// Shared types and helpers for the memory-to-stream descriptor engine.
// Holds the FSM state enum, the fixed memory latency and the keep-mask helper.
package axis_dma_pkg;

  // Synchronous-read memory: data returns one cycle after the strobe.
  localparam int MEM_LATENCY = 1;
  localparam int MAX_KEEP    = 128;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  // Low `rem` bits set; a zero remainder means the last beat is full.
  function automatic logic [MAX_KEEP-1:0] keep_mask(
    input int rem,
    input int bpb
  );
    logic [MAX_KEEP-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_KEEP; i++)
      m[i] = (rem == 0) ? (i < bpb) : (i < rem);
    return m;
  endfunction

endpackage

// File: rtl/axis_skid_fifo.sv
// Two-entry buffer between the memory read port and the stream output.
// Ports: clk/rst, push + push_data, pop, valid/data head, count occupancy.
module axis_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign valid = (count != 2'd0);
  assign data  = mem[rd_ptr];

endmodule

// File: rtl/axis_mm2s_desc.sv
// Descriptor-driven memory-to-AXI-Stream reader with byte keep on the tail.
// Ports: s_desc_* descriptor in, mem_* sync-read port, m_* stream, done/busy.
module axis_mm2s_desc
  import axis_dma_pkg::*;
#(
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 24
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_desc_valid,
  output logic                    s_desc_ready,
  input  logic [ADDR_WIDTH-1:0]   s_desc_addr,
  input  logic [LEN_WIDTH-1:0]    s_desc_len,
  output logic                    mem_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [BUS_WIDTH-1:0]    mem_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [BUS_WIDTH-1:0]    m_data,
  output logic [BUS_WIDTH/8-1:0]  m_keep,
  output logic                    m_last,
  output logic                    done,
  output logic                    busy
);

  localparam int BPB = BUS_WIDTH / 8;
  localparam int FW  = BUS_WIDTH + BPB + 1;

  state_t               state;
  logic [LEN_WIDTH-1:0] remain;
  logic [BPB-1:0]       last_keep;
  logic                 rd_vld;
  logic [BPB-1:0]       rd_keep;
  logic                 rd_last;

  logic                 accept;
  logic                 pop;
  logic                 issue;
  logic                 is_last;
  logic [1:0]           cnt;
  logic [2:0]           occ;
  logic [BPB-1:0]       issue_keep;
  logic [LEN_WIDTH-1:0] len_rem;
  logic [LEN_WIDTH-1:0] beats;
  logic [MAX_KEEP-1:0]  mask_full;
  logic [BPB-1:0]       len_keep;
  logic [BUS_WIDTH-1:0] byte_mask;
  logic [FW-1:0]        fifo_in;
  logic [FW-1:0]        fifo_out;

  assign accept  = s_desc_valid & s_desc_ready;
  assign pop     = m_valid & m_ready;
  assign is_last = (remain == LEN_WIDTH'(1));

  // Occupancy after this cycle's pop; counting the pop keeps one
  // beat per cycle flowing with only two buffer slots.
  assign occ   = 3'(cnt) + 3'(rd_vld) - 3'(pop);
  assign issue = (state == READ) && (occ < 3'd2);

  assign mem_en     = issue;
  assign issue_keep = is_last ? last_keep : '1;

  assign len_rem = s_desc_len % LEN_WIDTH'(BPB);
  assign beats   = s_desc_len / LEN_WIDTH'(BPB)
                 + LEN_WIDTH'(len_rem != '0);

  always_comb begin
    mask_full = keep_mask(int'(32'(len_rem)), BPB);
    len_keep  = mask_full[BPB-1:0];
  end

  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < BPB; i++)
      byte_mask[8*i +: 8] = {8{rd_keep[i]}};
  end

  assign fifo_in = {rd_last, rd_keep, mem_rdata & byte_mask};

  axis_skid_fifo #(
    .WIDTH(FW)
  ) u_fifo (
    .clk      (aclk),
    .rst      (areset),
    .push     (rd_vld),
    .push_data(fifo_in),
    .pop      (pop),
    .valid    (m_valid),
    .data     (fifo_out),
    .count    (cnt)
  );

  assign m_last = fifo_out[FW-1];
  assign m_keep = fifo_out[BUS_WIDTH +: BPB];
  assign m_data = fifo_out[BUS_WIDTH-1:0];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      s_desc_ready <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_addr     <= '0;
      remain       <= '0;
      last_keep    <= '0;
      rd_vld       <= 1'b0;
      rd_keep      <= '0;
      rd_last      <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_vld  <= issue;
      rd_keep <= issue_keep;
      rd_last <= issue & is_last;
      unique case (state)
        IDLE: begin
          s_desc_ready <= 1'b1;
          if (accept) begin
            if (beats == '0) begin
              done <= 1'b1;
            end else begin
              state        <= READ;
              s_desc_ready <= 1'b0;
              busy         <= 1'b1;
              mem_addr     <= s_desc_addr;
              remain       <= beats;
              last_keep    <= len_keep;
            end
          end
        end
        READ: begin
          if (issue) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            remain   <= remain - LEN_WIDTH'(1);
            if (is_last)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state        <= IDLE;
            s_desc_ready <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_mm2s_desc.sv
// Directed bench for axis_mm2s_desc with a sync-read memory model.
// Checks keep/last/data per beat, address sequence, done timing and reset.
module tb_axis_mm2s_desc;

  localparam int BW = 64;
  localparam int AW = 16;
  localparam int LW = 24;
  localparam int NB = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          s_desc_valid = 1'b0;
  logic          s_desc_ready;
  logic [AW-1:0] s_desc_addr = '0;
  logic [LW-1:0] s_desc_len = '0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [BW-1:0] m_data;
  logic [NB-1:0] m_keep;
  logic          m_last;
  logic          done;
  logic          busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_cyc = 0;
  int vrise = 0;
  logic rnd_ready = 1'b0;

  logic [BW-1:0] q_data[$];
  logic [NB-1:0] q_keep[$];
  logic          q_last[$];
  logic [AW-1:0] q_addr[$];

  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic [BW+NB:0] prev_b = '0;

  axis_mm2s_desc #(
    .BUS_WIDTH (BW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_desc_valid(s_desc_valid),
    .s_desc_ready(s_desc_ready),
    .s_desc_addr (s_desc_addr),
    .s_desc_len  (s_desc_len),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_keep      (m_keep),
    .m_last      (m_last),
    .done        (done),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  function automatic logic [63:0] word(input logic [15:0] a);
    logic [63:0] w;
    for (int b = 0; b < 8; b++)
      w[8*b +: 8] = a[7:0] + 8'(a[15:8] * 8'd3) + 8'(b * 37) + 8'h11;
    return w;
  endfunction

  function automatic logic [7:0] keepm(input int r);
    logic [7:0] k;
    k = 8'hFF;
    if (r != 0) k = k >> (8 - r);
    return k;
  endfunction

  function automatic logic [63:0] expw(input logic [15:0] a, input logic [7:0] k);
    logic [63:0] w;
    w = word(a);
    for (int b = 0; b < 8; b++)
      if (!k[b]) w[8*b +: 8] = 8'h00;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge aclk);
    cyc = cyc + 1;
    if (mem_en) mem_rdata <= word(mem_addr);
  end

  initial forever begin
    @(posedge aclk);
    #1;
    m_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  initial forever begin
    @(negedge aclk);
    if (areset) begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (prev_v && !prev_r)
        chk("stable", 128'({m_valid, m_last, m_keep, m_data}), 128'({1'b1, prev_b}));
      if (m_valid && m_ready) begin
        q_data.push_back(m_data);
        q_keep.push_back(m_keep);
        q_last.push_back(m_last);
        last_cyc = cyc;
      end
      if (mem_en) q_addr.push_back(mem_addr);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_valid && !prev_v) vrise++;
      prev_v = m_valid;
      prev_r = m_ready;
      prev_b = {m_last, m_keep, m_data};
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_keep.delete();
    q_last.delete();
    q_addr.delete();
    done_cnt = 0;
    vrise = 0;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n;
    n = 0;
    @(posedge aclk);
    #1;
    s_desc_valid = 1'b1;
    s_desc_addr = a;
    s_desc_len = l;
    while (!s_desc_ready && n < 100) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("acc_wait", 128'(n < 100), 128'(1));
    @(posedge aclk);
    #1;
    s_desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      @(negedge aclk);
      #1;
      k++;
    end
    chk("done_wait", 128'(done_cnt >= n), 128'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
    #1;
  endtask

  initial begin
    @(negedge aclk);
    chk("rst_out", 128'({s_desc_ready, mem_en, m_valid, m_last, done, busy, m_keep, m_data}), 128'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("rdy_pre", 128'(s_desc_ready), 128'(0));
    @(negedge aclk);
    chk("rdy_post", 128'(s_desc_ready), 128'(1));

    // 20 bytes from 0x10: keep FF, FF, 0F
    clear_mon();
    send(16'h0010, 24'd20);
    @(negedge aclk);
    chk("t1_n1", 128'({m_valid, mem_en, busy, s_desc_ready}), 128'(4'b0110));
    @(negedge aclk);
    chk("t1_n2", 128'(m_valid), 128'(0));
    @(negedge aclk);
    chk("t1_n3", 128'(m_valid), 128'(1));
    wait_done(1, 200);
    idle(3);
    chk("t1_nbeat", 128'(q_data.size()), 128'(3));
    if (q_data.size() == 3) begin
      chk("t1_b0", 128'({q_last[0], q_keep[0], q_data[0]}), 128'({1'b0, 8'hFF, expw(16'h10, 8'hFF)}));
      chk("t1_b1", 128'({q_last[1], q_keep[1], q_data[1]}), 128'({1'b0, 8'hFF, expw(16'h11, 8'hFF)}));
      chk("t1_b2", 128'({q_last[2], q_keep[2], q_data[2]}), 128'({1'b1, 8'h0F, expw(16'h12, 8'h0F)}));
    end
    chk("t1_addr", 128'(q_addr.size() == 3 && q_addr[0] == 16'h10 && q_addr[2] == 16'h12), 128'(1));
    chk("t1_done_lat", 128'(done_cyc - last_cyc), 128'(1));
    chk("t1_done_cnt", 128'(done_cnt), 128'(1));
    chk("t1_busy", 128'({busy, s_desc_ready}), 128'(2'b01));

    // 100 bytes with 30% m_ready
    clear_mon();
    rnd_ready = 1'b1;
    send(16'h0100, 24'd100);
    wait_done(1, 3000);
    rnd_ready = 1'b0;
    idle(4);
    chk("t2_nbeat", 128'(q_data.size()), 128'(13));
    for (int i = 0; i < 13 && i < q_data.size(); i++) begin
      logic [7:0] k;
      k = (i == 12) ? 8'h0F : 8'hFF;
      chk("t2_beat", 128'({q_last[i], q_keep[i], q_data[i]}),
          128'({i == 12, k, expw(16'h0100 + 16'(i), k)}));
    end

    // zero length
    clear_mon();
    send(16'h0020, 24'd0);
    @(negedge aclk);
    chk("t3_done", 128'({done, busy}), 128'(2'b10));
    @(negedge aclk);
    chk("t3_done_off", 128'(done), 128'(0));
    idle(8);
    chk("t3_cnt", 128'(done_cnt), 128'(1));
    chk("t3_novalid", 128'(vrise), 128'(0));
    chk("t3_rdy", 128'(s_desc_ready), 128'(1));

    // address wrap
    clear_mon();
    send(16'hFFFF, 24'd16);
    wait_done(1, 200);
    idle(3);
    chk("t4_naddr", 128'(q_addr.size()), 128'(2));
    if (q_addr.size() == 2)
      chk("t4_addr", 128'({q_addr[0], q_addr[1]}), 128'({16'hFFFF, 16'h0000}));
    if (q_data.size() == 2)
      chk("t4_b1", 128'({q_last[1], q_keep[1], q_data[1]}), 128'({1'b1, 8'hFF, expw(16'h0000, 8'hFF)}));

    // reset in the middle of an 8-beat packet
    clear_mon();
    send(16'h0200, 24'd64);
    begin
      int k;
      k = 0;
      while (q_data.size() < 2 && k < 200) begin
        @(negedge aclk);
        #1;
        k++;
      end
      chk("t5_wait", 128'(q_data.size() >= 2), 128'(1));
    end
    areset = 1'b1;
    #1;
    chk("t5_rst_out", 128'({s_desc_ready, mem_en, m_valid, m_last, done, busy, m_keep, m_data}), 128'(0));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    chk("t5_rdy_pre", 128'(s_desc_ready), 128'(0));
    @(posedge aclk);
    #1;
    chk("t5_rdy_post", 128'(s_desc_ready), 128'(1));
    clear_mon();
    send(16'h0040, 24'd8);
    wait_done(1, 200);
    idle(6);
    chk("t5_nbeat", 128'(q_data.size()), 128'(1));
    if (q_data.size() >= 1)
      chk("t5_b0", 128'({q_last[0], q_keep[0], q_data[0]}), 128'({1'b1, 8'hFF, expw(16'h0040, 8'hFF)}));

    // back-to-back 8 then 3 bytes
    clear_mon();
    send(16'h0050, 24'd8);
    send(16'h0060, 24'd3);
    wait_done(2, 200);
    idle(4);
    chk("t6_done_cnt", 128'(done_cnt), 128'(2));
    chk("t6_nbeat", 128'(q_data.size()), 128'(2));
    if (q_data.size() == 2) begin
      chk("t6_b0", 128'({q_last[0], q_keep[0], q_data[0]}), 128'({1'b1, 8'hFF, expw(16'h0050, 8'hFF)}));
      chk("t6_b1", 128'({q_last[1], q_keep[1], q_data[1]}), 128'({1'b1, keepm(3), expw(16'h0060, keepm(3))}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/axis_mm2s_desc.md
AXIS_MM2S_DESC -- requirements
Module: axis_mm2s_desc

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, stream data width in bits (multiple of 8, >= 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, memory word-address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 24, descriptor byte-length width.
REQ-004 SHALL have parameter MEM_LATENCY fixed at 1 (synchronous-read memory), not user-overridable.
REQ-005 SHALL derive BYTES_PER_BEAT = BUS_WIDTH/8.
REQ-006 SHALL have port aclk, input, 1, the only clock; all logic rises on posedge aclk.
REQ-007 SHALL have port areset, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port s_desc_valid, input, 1, descriptor offered.
REQ-009 SHALL have port s_desc_ready, output, 1, descriptor accepted when both valid and ready are high.
REQ-010 SHALL have port s_desc_addr, input, ADDR_WIDTH, start word address.
REQ-011 SHALL have port s_desc_len, input, LEN_WIDTH, transfer length in bytes.
REQ-012 SHALL have port mem_en, output, 1, memory read strobe.
REQ-013 SHALL have port mem_addr, output, ADDR_WIDTH, read word address.
REQ-014 SHALL have port mem_rdata, input, BUS_WIDTH, read data valid one cycle after mem_en.
REQ-015 SHALL have ports m_valid/m_ready, output/input, 1 each, AXI-Stream handshake.
REQ-016 SHALL have port m_data, output, BUS_WIDTH, stream data; byte i = bits [8i+7:8i].
REQ-017 SHALL have port m_keep, output, BYTES_PER_BEAT, byte-valid mask.
REQ-018 SHALL have port m_last, output, 1, final beat of a descriptor.
REQ-019 SHALL have port done, output, 1, one-cycle pulse when the last beat handshakes or a zero-length descriptor is retired.
REQ-020 SHALL have port busy, output, 1, high from descriptor accept until done.

Function
REQ-021 SHALL use states IDLE, READ, DRAIN: IDLE->READ on descriptor accept with len>0; READ->DRAIN when the final mem_en issues; DRAIN->IDLE on the m_last handshake.
REQ-022 SHALL accept a descriptor only in IDLE, with s_desc_ready registered and high only in IDLE.
REQ-023 SHALL retire a len=0 descriptor with a done pulse on the cycle after accept, emit no beat, and stay in IDLE.
REQ-024 SHALL compute beats = ceil(len/BYTES_PER_BEAT) and read words addr .. addr+beats-1; word address SHALL wrap modulo 2^ADDR_WIDTH.
REQ-025 SHALL set m_keep all-ones on every beat except the last; the last beat SHALL have the low (len mod BYTES_PER_BEAT) bits set, or all ones if that remainder is 0.
REQ-026 SHALL force m_data bytes with m_keep=0 to zero.
REQ-027 SHALL buffer read data in a 2-entry skid FIFO and issue mem_en only when (entries occupied + reads in flight) < 2, so no read data is ever lost.
REQ-028 SHALL sustain one beat per cycle while m_ready stays high; first m_valid SHALL appear 2 cycles after descriptor accept.
REQ-029 SHALL keep m_data/m_keep/m_last stable while m_valid is high and m_ready is low (AXIS rule); m_valid SHALL NOT depend combinationally on m_ready.
REQ-030 SHALL drive m_last high only on the final beat of each descriptor.
REQ-031 SHALL keep a 1-beat descriptor (len <= BYTES_PER_BEAT) going READ->DRAIN in a single cycle.

Reset
REQ-032 SHALL, when areset is asserted (any time, including mid-transfer), immediately drive s_desc_ready, mem_en, m_valid, m_last, done and busy to 0, m_keep and m_data to 0, flush the FIFO, and set state to IDLE.
REQ-033 SHALL raise s_desc_ready on the first posedge after areset deasserts; a partial packet SHALL NOT resume.

Structure
REQ-034 SHALL place the state enum and the keep-mask function (remainder to mask) in a shared package, axis_dma_pkg.
REQ-035 SHALL implement the 2-entry buffer as sub-module axis_skid_fifo (parametrised by width), holding data, keep and last.

Verification
REQ-036 SHALL test BUS_WIDTH=64, addr=0x10, len=20 with m_ready=1: 3 beats, keep FF,FF,0F, m_last on beat 3, done 1 cycle after beat 3.
REQ-037 SHALL test random m_ready at 30% high over a 100-byte descriptor: stream bytes match memory exactly, no drop or duplicate, payload stable while stalled.
REQ-038 SHALL test len=0: done pulses once, m_valid never rises, s_desc_ready returns high.
REQ-039 SHALL test addr=0xFFFF, len=16 with ADDR_WIDTH=16: mem_addr sequence FFFF, 0000.
REQ-040 SHALL test areset asserted after beat 2 of 8: outputs 0 that cycle; a new len=8 descriptor then yields 1 beat with keep FF and m_last.
REQ-041 SHALL test back-to-back descriptors len=8 then len=3 at BUS_WIDTH=64: second packet is 1 beat, keep 07, and done pulses twice.
